axis_stall_detector: RTL and testbench

- Per-instance front end that turns raw AXI-Stream valid/ready activity on an HLS instance's ports into debounced per-channel block flags.
- Its block vector feeds the axis_block_sigs input of the per-instance deadlock monitor.
- Also provides a lowest-index "first stalled channel" capture and a sticky long-stall flag for debug readout.

---
 rtl/axis_stall_pkg.sv | 22 ++
 rtl/axis_stall_ch.sv | 55 +++++
 rtl/axis_stall_detector.sv | 147 ++++++++++++++
 tb/tb_axis_stall_detector.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_stall_pkg.sv
// Shared types, defaults and width helper for the AXI-Stream stall detector.
package axis_stall_pkg;

  // Global stall-tracking FSM states.
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STALL   = 2'd1,
    S_LATCHED = 2'd2
  } stall_state_t;

  localparam int unsigned DEF_NUM_CH       = 3;
  localparam int unsigned DEF_CH_IS_INPUT  = 1;
  localparam int unsigned DEF_STALL_THRESH = 4;
  localparam int unsigned DEF_HOLD_THRESH  = 256;
  localparam int unsigned STATS_W          = 16;

  // clog2 with a floor of one bit, so single-value ranges still get a wire.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_stall_ch.sv
// Single-channel stall debounce: raw stall condition, saturating run counter,
// registered block flag plus its next-state value for the global logic.
module axis_stall_ch
  import axis_stall_pkg::*;
#(
  parameter bit          IS_INPUT     = 1'b0,
  parameter int unsigned STALL_THRESH = DEF_STALL_THRESH
) (
  input  logic clock,
  input  logic reset,
  input  logic tvalid,
  input  logic tready,
  input  logic inst_idle,
  output logic block,
  output logic block_nxt_c
);

  localparam int unsigned    CW       = width_of(STALL_THRESH + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(STALL_THRESH);
  localparam logic [CW-1:0]  CNT_TRIP = CW'(STALL_THRESH - 1);

  logic          cond_c;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  // Starved consumer or backpressured producer; an idle instance never stalls.
  always_comb begin
    cond_c = 1'b0;
    if (!inst_idle) begin
      cond_c = IS_INPUT ? (tready & ~tvalid) : (tvalid & ~tready);
    end
  end

  // Saturating run length of consecutive stall cycles and the next flag value.
  always_comb begin
    cnt_nxt_c   = '0;
    block_nxt_c = 1'b0;
    if (cond_c) begin
      cnt_nxt_c   = (cnt >= CNT_MAX) ? CNT_MAX : cnt + CW'(1);
      block_nxt_c = (cnt >= CNT_TRIP);
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      block <= 1'b0;
    end else begin
      cnt   <= cnt_nxt_c;
      block <= block_nxt_c;
    end
  end

endmodule

// File: rtl/axis_stall_detector.sv
// Per-instance AXI-Stream stall detector: debounced per-channel block flags,
// first-blocked-channel capture and a sticky long-stall flag.
// Optional macro AXIS_STALL_DETECTOR_STATS_EN adds a 16-bit stall_events count.
module axis_stall_detector
  import axis_stall_pkg::*;
#(
  parameter int unsigned       NUM_CH       = DEF_NUM_CH,
  parameter logic [NUM_CH-1:0] CH_IS_INPUT  = NUM_CH'(DEF_CH_IS_INPUT),
  parameter int unsigned       STALL_THRESH = DEF_STALL_THRESH,
  parameter int unsigned       HOLD_THRESH  = DEF_HOLD_THRESH,
  localparam int unsigned      FCW          = width_of(NUM_CH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic              inst_idle,
  input  logic              clear_sticky,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              stall_any,
  output logic              first_ch_valid,
  output logic [FCW-1:0]    first_ch,
  output logic              sticky_stall
`ifdef AXIS_STALL_DETECTOR_STATS_EN
  , output logic [STATS_W-1:0] stall_events
`endif
);

  localparam int unsigned   HW        = width_of(HOLD_THRESH + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_THRESH);
  localparam logic [HW-1:0] HOLD_TRIP = HW'(HOLD_THRESH - 1);

  logic [NUM_CH-1:0] block_nxt_c;
  logic              any_nxt_c;
  logic [FCW-1:0]    low_idx_c;

  stall_state_t      state;
  stall_state_t      state_nxt_c;
  logic [HW-1:0]     hcnt;
  logic [HW-1:0]     hcnt_nxt_c;
  logic              sticky_nxt_c;
  logic              first_valid_nxt_c;
  logic [FCW-1:0]    first_ch_nxt_c;

  // One debounce slice per monitored channel.
  for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : g_ch
    axis_stall_ch #(
      .IS_INPUT    (CH_IS_INPUT[gi]),
      .STALL_THRESH(STALL_THRESH)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .tvalid     (ch_tvalid[gi]),
      .tready     (ch_tready[gi]),
      .inst_idle  (inst_idle),
      .block      (axis_block_sigs[gi]),
      .block_nxt_c(block_nxt_c[gi])
    );
  end

  // Any-block and lowest blocked index, both from next-state flags.
  always_comb begin
    any_nxt_c = |block_nxt_c;
    low_idx_c = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (block_nxt_c[i]) low_idx_c = FCW'(i);
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_RUN;
    else       state <= state_nxt_c;
  end

  // FSM next-state logic; a clear during the final hold cycle restarts the hold.
  always_comb begin
    state_nxt_c = state;
    case (state)
      S_RUN:     if (any_nxt_c) state_nxt_c = S_STALL;
      S_STALL: begin
        if (!any_nxt_c)                              state_nxt_c = S_RUN;
        else if (!clear_sticky && hcnt >= HOLD_TRIP) state_nxt_c = S_LATCHED;
      end
      S_LATCHED: if (clear_sticky) state_nxt_c = S_RUN;
      default:   state_nxt_c = S_RUN;
    endcase
  end

  // Next values for hold counter, sticky flag and first-channel capture.
  always_comb begin
    hcnt_nxt_c        = hcnt;
    first_valid_nxt_c = first_ch_valid;
    first_ch_nxt_c    = first_ch;
    sticky_nxt_c      = (state_nxt_c == S_LATCHED);
    case (state)
      S_RUN, S_STALL: begin
        if (clear_sticky) begin
          first_valid_nxt_c = 1'b0;
          first_ch_nxt_c    = '0;
        end else if (!first_ch_valid && any_nxt_c) begin
          first_valid_nxt_c = 1'b1;
          first_ch_nxt_c    = low_idx_c;
        end
        if (state == S_RUN || !any_nxt_c || clear_sticky) hcnt_nxt_c = '0;
        else hcnt_nxt_c = (hcnt >= HOLD_MAX) ? HOLD_MAX : hcnt + HW'(1);
      end
      S_LATCHED: begin
        if (clear_sticky) begin
          hcnt_nxt_c        = '0;
          first_valid_nxt_c = 1'b0;
          first_ch_nxt_c    = '0;
        end
      end
      default: hcnt_nxt_c = '0;
    endcase
  end

  // Registered global outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      hcnt           <= '0;
      stall_any      <= 1'b0;
      sticky_stall   <= 1'b0;
      first_ch_valid <= 1'b0;
      first_ch       <= '0;
    end else begin
      hcnt           <= hcnt_nxt_c;
      stall_any      <= any_nxt_c;
      sticky_stall   <= sticky_nxt_c;
      first_ch_valid <= first_valid_nxt_c;
      first_ch       <= first_ch_nxt_c;
    end
  end

`ifdef AXIS_STALL_DETECTOR_STATS_EN
  // Saturating count of stall episodes (run -> stall entries).
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_events <= '0;
    end else if (state == S_RUN && state_nxt_c == S_STALL && stall_events != '1) begin
      stall_events <= stall_events + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_stall_detector.sv
// Self-checking bench for axis_stall_detector (3 channels, ch0 input,
// STALL_THRESH 4, HOLD_THRESH 8) with a run-length/timestamp reference model.
module tb_axis_stall_detector;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned STALL  = 4;
  localparam int unsigned HOLD   = 8;
  localparam logic [NUM_CH-1:0] IS_IN = 3'b001;

  logic              clock;
  logic              reset;
  logic [NUM_CH-1:0] ch_tvalid;
  logic [NUM_CH-1:0] ch_tready;
  logic              inst_idle;
  logic              clear_sticky;
  logic [NUM_CH-1:0] axis_block_sigs;
  logic              stall_any;
  logic              first_ch_valid;
  logic [1:0]        first_ch;
  logic              sticky_stall;
`ifdef AXIS_STALL_DETECTOR_STATS_EN
  logic [15:0]       stall_events;
`endif

  axis_stall_detector #(
    .NUM_CH      (NUM_CH),
    .CH_IS_INPUT (IS_IN),
    .STALL_THRESH(STALL),
    .HOLD_THRESH (HOLD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ch_tvalid      (ch_tvalid),
    .ch_tready      (ch_tready),
    .inst_idle      (inst_idle),
    .clear_sticky   (clear_sticky),
    .axis_block_sigs(axis_block_sigs),
    .stall_any      (stall_any),
    .first_ch_valid (first_ch_valid),
    .first_ch       (first_ch),
`ifdef AXIS_STALL_DETECTOR_STATS_EN
    .stall_events   (stall_events),
`endif
    .sticky_stall   (sticky_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;

  // Reference model state: consecutive-stall run lengths and episode timestamps.
  int                run_len [NUM_CH];
  int                cyc;
  int                ep_start;
  int                m_events;
  logic              m_episode;
  logic [NUM_CH-1:0] m_blk;
  logic              m_any;
  logic              m_valid;
  logic [1:0]        m_first;
  logic              m_sticky;

  // Advance the model by one clock edge using the inputs held during the cycle.
  task automatic model_edge();
    logic [NUM_CH-1:0] nb;
    logic              cond;
    cyc++;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
      m_blk = '0; m_any = 1'b0; m_valid = 1'b0; m_first = '0;
      m_sticky = 1'b0; m_episode = 1'b0; m_events = 0;
    end else begin
      nb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (IS_IN[i]) cond = ch_tready[i] && !ch_tvalid[i];
        else          cond = ch_tvalid[i] && !ch_tready[i];
        if (inst_idle) cond = 1'b0;
        run_len[i] = cond ? run_len[i] + 1 : 0;
        nb[i] = cond && (run_len[i] >= STALL);
      end
      if (m_sticky) begin
        if (clear_sticky) begin
          m_sticky = 1'b0; m_valid = 1'b0; m_first = '0;
        end
      end else begin
        if (clear_sticky) begin
          m_valid = 1'b0; m_first = '0;
        end else if (!m_valid && nb != '0) begin
          m_valid = 1'b1;
          for (int i = NUM_CH - 1; i >= 0; i--) if (nb[i]) m_first = 2'(i);
        end
        if (m_episode) begin
          if (nb == '0)                  m_episode = 1'b0;
          else if (clear_sticky)         ep_start = cyc;
          else if (cyc - ep_start >= HOLD) begin
            m_sticky = 1'b1; m_episode = 1'b0;
          end
        end else if (nb != '0) begin
          m_episode = 1'b1;
          ep_start  = cyc;
          if (m_events < 65535) m_events++;
        end
      end
      m_blk = nb;
      m_any = |nb;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    ch_tvalid = '0; ch_tready = '0; inst_idle = 1'b0; clear_sticky = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    repeat (3) tick();
    checks++; if (axis_block_sigs !== 3'b000) begin errors++; $display("FAIL reset_blk got %b want 000", axis_block_sigs); end
    checks++; if (stall_any !== 1'b0) begin errors++; $display("FAIL reset_any got %b want 0", stall_any); end
    checks++; if (first_ch_valid !== 1'b0 || first_ch !== 2'd0) begin errors++; $display("FAIL reset_first got %b/%0d want 0/0", first_ch_valid, first_ch); end
    checks++; if (sticky_stall !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", sticky_stall); end
    reset = 1'b0;
  endtask

  task automatic test_input_starve();
    logic [NUM_CH-1:0] exp;
    ch_tready = 3'b001; ch_tvalid = 3'b000;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp = (k >= int'(STALL)) ? 3'b001 : 3'b000;
      checks++;
      if (axis_block_sigs !== exp || stall_any !== (exp != '0)) begin
        errors++; $display("FAIL starve_flag k=%0d got %b/%b want %b/%b", k, axis_block_sigs, stall_any, exp, exp != '0);
      end
    end
    checks++; if (first_ch_valid !== 1'b1 || first_ch !== 2'd0) begin errors++; $display("FAIL starve_first got %b/%0d want 1/0", first_ch_valid, first_ch); end
    idle_inputs();
    tick();
    checks++; if (axis_block_sigs !== 3'b000) begin errors++; $display("FAIL starve_release got %b want 000", axis_block_sigs); end
  endtask

  task automatic test_transfer_break();
    ch_tvalid = 3'b100; ch_tready = 3'b000;
    repeat (3) begin
      tick();
      checks++; if (axis_block_sigs !== 3'b000) begin errors++; $display("FAIL xfer_pre got %b want 000", axis_block_sigs); end
    end
    ch_tready = 3'b100;
    tick();
    checks++; if (axis_block_sigs !== 3'b000 || m_blk !== 3'b000) begin errors++; $display("FAIL xfer_cycle got %b want 000", axis_block_sigs); end
    ch_tready = 3'b000;
    repeat (3) begin
      tick();
      checks++; if (axis_block_sigs[2] !== 1'b0) begin errors++; $display("FAIL xfer_restart got %b want 0", axis_block_sigs[2]); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    checks++; if (first_ch_valid !== 1'b0) begin errors++; $display("FAIL simul_clear got %b want 0", first_ch_valid); end
    ch_tvalid = 3'b110; ch_tready = 3'b000;
    for (int k = 1; k <= int'(STALL); k++) begin
      tick();
      if (k < int'(STALL)) begin
        checks++; if (axis_block_sigs !== 3'b000) begin errors++; $display("FAIL simul_early k=%0d got %b want 000", k, axis_block_sigs); end
      end
    end
    checks++; if (axis_block_sigs !== 3'b110 || stall_any !== 1'b1) begin errors++; $display("FAIL simul_flags got %b/%b want 110/1", axis_block_sigs, stall_any); end
    checks++; if (first_ch_valid !== 1'b1 || first_ch !== 2'd1) begin errors++; $display("FAIL simul_first got %b/%0d want 1/1", first_ch_valid, first_ch); end
  endtask

  task automatic test_idle_mask();
    tick();
    inst_idle = 1'b1;
    tick();
    checks++; if (axis_block_sigs !== 3'b000 || stall_any !== 1'b0) begin errors++; $display("FAIL idle_mask got %b/%b want 000/0", axis_block_sigs, stall_any); end
    checks++; if ({first_ch_valid, first_ch} !== {m_valid, m_first}) begin errors++; $display("FAIL idle_first got %b%0d want %b%0d", first_ch_valid, first_ch, m_valid, m_first); end
    idle_inputs();
    tick();
  endtask

  task automatic test_sticky();
    bit seen;
    reset = 1'b1; tick(); reset = 1'b0;
    ch_tready = 3'b001;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = stall_any;
    end
    checks++; if (!seen) begin errors++; $display("FAIL sticky_wait got stall_any=0 want 1 within 20 cycles"); end
    for (int k = 1; k <= int'(HOLD); k++) begin
      tick();
      checks++;
      if (sticky_stall !== (k == int'(HOLD))) begin errors++; $display("FAIL sticky_rise k=%0d got %b want %b", k, sticky_stall, k == int'(HOLD)); end
    end
    ch_tready = 3'b000;
    repeat (3) tick();
    checks++; if (sticky_stall !== 1'b1 || axis_block_sigs !== 3'b000) begin errors++; $display("FAIL sticky_hold got %b/%b want 1/000", sticky_stall, axis_block_sigs); end
    clear_sticky = 1'b1;
    tick();
    clear_sticky = 1'b0;
    checks++; if (sticky_stall !== 1'b0 || first_ch_valid !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b/%b want 0/0", sticky_stall, first_ch_valid); end
  endtask

  task automatic test_reset_latched();
    bit seen;
    ch_tready = 3'b001;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      tick();
      seen = sticky_stall;
    end
    checks++; if (!seen) begin errors++; $display("FAIL latch_wait got sticky=0 want 1 within 40 cycles"); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({axis_block_sigs, stall_any, first_ch_valid, first_ch, sticky_stall} !== 8'h00) begin
      errors++; $display("FAIL latch_reset got %b want 00000000", {axis_block_sigs, stall_any, first_ch_valid, first_ch, sticky_stall});
    end
`ifdef AXIS_STALL_DETECTOR_STATS_EN
    checks++; if (stall_events !== 16'd0) begin errors++; $display("FAIL latch_reset_events got %0d want 0", stall_events); end
`endif
    for (int k = 1; k <= int'(STALL); k++) begin
      tick();
      checks++;
      if (axis_block_sigs !== ((k == int'(STALL)) ? 3'b001 : 3'b000)) begin errors++; $display("FAIL post_reset_flag k=%0d got %b", k, axis_block_sigs); end
    end
    idle_inputs();
    tick();
  endtask

`ifdef AXIS_STALL_DETECTOR_STATS_EN
  task automatic test_stats();
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (stall_events !== 16'd0) begin errors++; $display("FAIL stats_reset got %0d want 0", stall_events); end
    repeat (3) begin
      ch_tvalid = 3'b010; ch_tready = 3'b000;
      repeat (6) tick();
      idle_inputs();
      repeat (3) tick();
    end
    checks++; if (stall_events !== 16'd3) begin errors++; $display("FAIL stats_three got %0d want 3", stall_events); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] got;
    logic [7:0] exp;
    reset = 1'b1; tick(); reset = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) begin
            ch_tvalid[i] = !IS_IN[i];
            ch_tready[i] = IS_IN[i];
          end else begin
            ch_tvalid[i] = 1'($urandom_range(0, 1));
            ch_tready[i] = 1'($urandom_range(0, 1));
          end
        end
      end
      inst_idle    = ($urandom_range(0, 39) == 0);
      clear_sticky = ($urandom_range(0, 49) == 0);
      reset        = ($urandom_range(0, 399) == 0);
      tick();
      got = {axis_block_sigs, stall_any, first_ch_valid, first_ch, sticky_stall};
      exp = {m_blk, m_any, m_valid, m_first, m_sticky};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random n=%0d got %b want %b", n, got, exp); end
`ifdef AXIS_STALL_DETECTOR_STATS_EN
      checks++;
      if (stall_events !== 16'(m_events)) begin errors++; $display("FAIL random_events n=%0d got %0d want %0d", n, stall_events, m_events); end
`endif
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; ep_start = 0; m_events = 0;
    m_episode = 1'b0; m_blk = '0; m_any = 1'b0; m_valid = 1'b0; m_first = '0; m_sticky = 1'b0;
    for (int i = 0; i < NUM_CH; i++) run_len[i] = 0;
    test_reset();
    test_input_starve();
    test_transfer_break();
    test_simultaneous();
    test_idle_mask();
    test_sticky();
    test_reset_latched();
`ifdef AXIS_STALL_DETECTOR_STATS_EN
    test_stats();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
